// File: rtl/nmx1_wbm_pkg.sv
// Shared types and constants for the NEUROMORPHIC_X1 Wishbone initiator.
package nmx1_wbm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WDAT = 2'd1,
        BUS  = 2'd2,
        RSP  = 2'd3
    } wbm_state_e;

    localparam int WB_WORD_INC = 4;
    localparam int DEFAULT_AW  = 32;
    localparam int DEFAULT_DW  = 32;

endpackage

// File: rtl/nmx1_wbm_timeout.sv
// Strobe-wait watchdog: counts BUS cycles without ack, flags the final allowed cycle.
module nmx1_wbm_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // Count is zero on every BUS entry because run is low in all other states.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    assign expired = run && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/nmx1_wb_master.sv
// Wishbone classic initiator issuing 1..2^LEN_W single-cycle word beats per command.
// Optional strobe timeout enabled by defining NMX1_WBM_TIMEOUT_EN.
module nmx1_wb_master
    import nmx1_wbm_pkg::*;
#(
    parameter int AW          = DEFAULT_AW,
    parameter int DW          = DEFAULT_DW,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_dat,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic              busy,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [DW/8-1:0]   m_sel_o,
    output logic [AW-1:0]     m_adr_o,
    output logic [DW-1:0]     m_dat_o,
    input  logic              m_ack_i,
    input  logic [DW-1:0]     m_dat_i,
    output logic [1:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the offering side holds its payload stable until then.

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    wbm_state_e       state, state_nx;
    logic [LEN_W-1:0] cnt, len_q;
    logic             we_q, cyc_q, err_q, last_q;
    logic [AW-1:0]    adr_q;
    logic [DW/8-1:0]  sel_q;
    logic [DW-1:0]    wdat_q, rdat_q;
    logic             tmo;

`ifdef NMX1_WBM_TIMEOUT_EN
    nmx1_wbm_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .run    ((state == BUS) && !m_ack_i),
        .expired(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_nx = cmd_we ? WDAT : BUS;
            WDAT:    if (wdat_valid) state_nx = BUS;
            BUS:     if (m_ack_i || tmo) state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = last_q ? IDLE : (we_q ? WDAT : BUS);
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= '0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            sel_q  <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            err_q  <= 1'b0;
            last_q <= 1'b0;
            cyc_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (cmd_valid) begin
                    we_q  <= cmd_we;
                    adr_q <= cmd_adr;
                    sel_q <= cmd_sel;
                    len_q <= cmd_len;
                    cnt   <= '0;
                    cyc_q <= !cmd_we;
                end
                WDAT: if (wdat_valid) begin
                    wdat_q <= wdat_dat;
                    cyc_q  <= 1'b1;
                end
                BUS: if (m_ack_i) begin
                    rdat_q <= we_q ? '0 : m_dat_i;
                    err_q  <= 1'b0;
                    last_q <= (cnt == len_q);
                end else if (tmo) begin
                    // Abandon the rest of the burst and release the bus immediately.
                    rdat_q <= '0;
                    err_q  <= 1'b1;
                    last_q <= 1'b1;
                    cyc_q  <= 1'b0;
                end
                RSP: if (rsp_ready) begin
                    cnt <= cnt + LEN_W'(1);
                    if (last_q) cyc_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE) && !wb_rst_i;
    assign wdat_ready = (state == WDAT);
    assign rsp_valid  = (state == RSP);
    assign rsp_dat    = rdat_q;
    assign rsp_err    = err_q;
    assign rsp_last   = last_q;
    assign busy       = (state != IDLE);
    assign m_cyc_o    = cyc_q;
    assign m_stb_o    = (state == BUS);
    assign m_we_o     = we_q;
    assign m_sel_o    = sel_q;
    assign m_adr_o    = adr_q + AW'(cnt) * AW'(WB_WORD_INC);
    assign m_dat_o    = wdat_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_nmx1_wb_master.sv
// Self-checking bench for nmx1_wb_master: directed vector table, hand sequences, random commands.
module tb_nmx1_wb_master;

    localparam int TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [3:0]  cmd_len;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat_dat;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [31:0] rsp_dat;
    logic        busy, m_cyc_o, m_stb_o, m_we_o, m_ack_i;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [1:0]  state_dbg;

    nmx1_wb_master #(
        .AW(32), .DW(32), .LEN_W(4), .TIMEOUT_CYC(TO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_dat(wdat_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // scoreboard: {err, last, dat}
    logic [33:0] exp_q[$];

    bit          rdy_rand  = 1'b0;
    int          wgap_max  = 0;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_dat = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // slave memory contents as seen by reads
    function automatic logic [31:0] sdat(input logic [31:0] a);
        return fixed_en ? fixed_dat : ((a ^ 32'hC3A5_5A3C) + 32'd7);
    endfunction

    task automatic idle_inputs();
        cmd_valid  = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat_dat = '0;
        rsp_ready  = 1'b0;
        m_ack_i    = 1'b0; m_dat_i = '0;
    endtask

    // One complete command; the bench plays command source, write-data source,
    // Wishbone slave and response sink. Entered and left at a negedge.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input int len, input int ack_dly, input int stall_beat,
                           input int stall_n, input int rst_beat, output logic [31:0] last_adr);
        logic [31:0] wq[$];
        logic [31:0] exp_adr;
        logic [33:0] item;
        int k, wi, rn, scnt, stall_c, gap, pushed, budget;
        bit acc, started, cyc_off, done, hit_rst;
        exp_q.delete();
        for (int i = 0; i <= len; i++) wq.push_back($urandom);
        k = 0; wi = 0; rn = 0; scnt = 0; stall_c = 0; pushed = 0;
        gap = $urandom_range(0, wgap_max);
        acc = 0; started = 0; cyc_off = 0; done = 0; hit_rst = 0;
        last_adr = '0; exp_adr = adr;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = len[3:0];
        for (budget = 0; budget < 3000 && !done && !hit_rst; budget++) begin
            // observe
            started = started | m_stb_o;
            chk("busy", busy, acc);
            chk("cyc", m_cyc_o, started && !cyc_off);
            if (m_stb_o) begin
                exp_adr = adr + 32'(4 * k);
                chk("stb_adr", m_adr_o, exp_adr);
                chk("stb_we", m_we_o, we);
                chk("stb_sel", m_sel_o, sel);
                if (k > len) chk("stb_beats", k, len);
                else if (we) chk("stb_dat", m_dat_o, wq[k]);
                chk("stb_vs_rsp", rsp_valid, 1'b0);
                last_adr = m_adr_o;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
                else chk("rsp", {rsp_err, rsp_last, rsp_dat}, exp_q[0]);
            end
            // drive
            if (acc) cmd_valid = 1'b0;
            if (we && wi <= len) begin
                if (gap > 0) begin
                    wdat_valid = 1'b0; gap--;
                end else begin
                    wdat_valid = 1'b1; wdat_dat = wq[wi];
                end
            end else begin
                wdat_valid = 1'b0;
            end
            m_ack_i = 1'b0; m_dat_i = $urandom;
            if (m_stb_o) begin
                if (rst_beat == k) begin
                    wb_rst_i = 1'b1; hit_rst = 1;
                end else if (scnt == ack_dly) begin
                    m_ack_i = 1'b1; m_dat_i = sdat(exp_adr);
                end
            end
            if (rsp_valid && rn == stall_beat && stall_c < stall_n) begin
                rsp_ready = 1'b0; stall_c++;
            end else begin
                rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            // handshakes completing at the coming edge
            if (!hit_rst) begin
                if (cmd_valid && cmd_ready) acc = 1;
                if (wdat_valid && wdat_ready) begin
                    wi++; gap = $urandom_range(0, wgap_max);
                end
                if (m_stb_o) begin
                    if (m_ack_i) begin
                        exp_q.push_back({1'b0, (k == len), (we ? 32'h0 : sdat(exp_adr))});
                        pushed++; k++; scnt = 0;
                    end
`ifdef NMX1_WBM_TIMEOUT_EN
                    else if (scnt == TO - 1) begin
                        exp_q.push_back({1'b1, 1'b1, 32'h0});
                        pushed++; k = len + 1; scnt = 0; cyc_off = 1;
                    end
`endif
                    else scnt++;
                end
                if (rsp_valid && rsp_ready) begin
                    rn++;
                    if (exp_q.size() != 0) begin
                        item = exp_q.pop_front();
                        if (item[32]) done = 1;
                    end
                end
            end
            @(negedge wb_clk_i);
        end
        idle_inputs();
        if (hit_rst) begin
            chk("rst_cyc", m_cyc_o, 1'b0);
            chk("rst_stb", m_stb_o, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_cmd_ready_held", cmd_ready, 1'b0);
            wb_rst_i = 1'b0;
            exp_q.delete();
            @(negedge wb_clk_i);
            chk("rst_cmd_ready_after", cmd_ready, 1'b1);
        end else begin
            chk("cmd_done", done, 1'b1);
            chk("end_cyc", m_cyc_o, 1'b0);
            chk("end_stb", m_stb_o, 1'b0);
            chk("end_rsp_valid", rsp_valid, 1'b0);
            chk("end_busy", busy, 1'b0);
            chk("end_cmd_ready", cmd_ready, 1'b1);
            chk("rsp_count", rn, pushed);
            chk("rsp_left", exp_q.size(), 0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        int          len;
        int          ack_dly;
        int          wgap;
        int          stall_beat;
        int          stall_n;
        bit          fixed;
        logic [31:0] exp_last_adr;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] last_adr;

    initial begin
        vecs[0] = '{1'b0, 32'h3000_0010, 4'hF, 0,  2, 0, -1, 0, 1'b1, 32'h3000_0010};
        vecs[1] = '{1'b1, 32'h3000_0000, 4'hF, 3,  1, 3, -1, 0, 1'b0, 32'h3000_000C};
        vecs[2] = '{1'b0, 32'h3000_0100, 4'hF, 3,  0, 0,  1, 5, 1'b0, 32'h3000_010C};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 1,  1, 0, -1, 0, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h1234_5672, 4'h6, 2,  3, 2,  0, 3, 1'b0, 32'h1234_567A};
        vecs[5] = '{1'b0, 32'h4000_0000, 4'h3, 15, 0, 0, -1, 0, 1'b0, 32'h4000_003C};

        idle_inputs();
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cyc", m_cyc_o, 1'b0);
        chk("reset_stb", m_stb_o, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_wdat_ready", wdat_ready, 1'b0);
        chk("reset_adr", m_adr_o, 32'h0);
        chk("reset_we", m_we_o, 1'b0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // directed vector table
        fixed_dat = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            fixed_en = vecs[i].fixed;
            wgap_max = vecs[i].wgap;
            run_cmd(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].len, vecs[i].ack_dly,
                    vecs[i].stall_beat, vecs[i].stall_n, -1, last_adr);
            chk($sformatf("vec%0d_last_adr", i), last_adr, vecs[i].exp_last_adr);
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
        end
        fixed_en = 1'b0;
        wgap_max = 0;

        // reset pulsed during the strobe of beat 2 of a 4-beat read
        run_cmd(1'b0, 32'h3000_0200, 4'hF, 3, 2, -1, 0, 2, last_adr);
        chk("rst_seq_adr", last_adr, 32'h3000_0208);

`ifdef NMX1_WBM_TIMEOUT_EN
        // slave never acks: one error response ends the burst
        run_cmd(1'b0, 32'h3000_0300, 4'hF, 2, -1, -1, 0, -1, last_adr);
        chk("tmo_adr", last_adr, 32'h3000_0300);
        // ack on the last permitted cycle is a normal response
        run_cmd(1'b0, 32'h3000_0400, 4'hF, 1, TO - 1, -1, 0, -1, last_adr);
        chk("tmo_late_ack_adr", last_adr, 32'h3000_0404);
        run_cmd(1'b1, 32'h3000_0500, 4'hF, 1, -1, -1, 0, -1, last_adr);
`endif

        // randomized commands against the scoreboard model
        rdy_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            wgap_max = $urandom_range(0, 3);
            run_cmd($urandom_range(0, 1), $urandom, 4'($urandom_range(1, 15)),
                    $urandom_range(0, 7), $urandom_range(0, 3), -1, 0, -1, last_adr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
